axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
- Arbitrates two AXI read masters (M0, M1) onto one shared read path: AR channel and R channel.
- Generates the select pointers that steer the payload muxes for both channels.
- Gates the VALID/READY handshakes so only the granted master sees the shared path.
- One read transaction in flight at a time; round-robin between masters; grant held from AR handshake until the last R beat completes.

Parameters:
- LEN_BITS, 4, width of ARLEN (AXI3 burst length field).
- CNT_BITS, 4, width of internal beat counter; must be >= LEN_BITS.

Ports:
- ACLK  input  1  clock
- ARESETn  input  1  asynchronous active-low reset
- ARVALID_M0  input  1  M0 address-read request
- ARLEN_M0  input  LEN_BITS  M0 burst length (beats-1)
- ARREADY_M0  output  1  AR ready returned to M0
- ARVALID_M1  input  1  M1 address-read request
- ARLEN_M1  input  LEN_BITS  M1 burst length
- ARREADY_M1  output  1  AR ready returned to M1
- ARVALID_S  output  1  AR valid to shared slave side
- ARREADY_S  input  1  AR ready from shared slave side
- RVALID_S  input  1  R valid from shared slave side
- RLAST_S  input  1  R last from shared slave side
- RREADY_S  output  1  R ready to shared slave side
- RVALID_M0  output  1  R valid to M0
- RREADY_M0  input  1  R ready from M0
- RVALID_M1  output  1  R valid to M1
- RREADY_M1  input  1  R ready from M1
- ar_sel  output  `AXI_POINTER_BITS  AR payload mux select; Pointer encoding SEL0/SEL1
- r_sel  output  `AXI_POINTER_BITS  R payload mux select
- len_err  output  1  one-cycle pulse: RLAST beat count disagrees with captured ARLEN
- busy  output  1  high in ADDR or DATA

Behaviour:
- Clock and reset:
  - Single clock domain, ACLK.
  - ARESETn asynchronous assert, synchronous release.
- Reset values:
  - state=IDLE, last_grant=SEL1 (so M0 wins first), grant=SEL0, beat counter=0, captured len=0.
  - All VALID/READY outputs 0; len_err=0; busy=0.
  - ar_sel=r_sel=SEL0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - All handshake outputs 0.
  - Any ARVALID_Mx high -> pick grant and go to ADDR next cycle.
  - Both high: grant the master that is not last_grant.
  - One high: grant it.
  - The grant is registered; ARVALID_S rises no earlier than one cycle after the request (1-cycle arbitration latency).
- ADDR:
  - ar_sel=grant.
  - ARVALID_S = ARVALID of the granted master.
  - ARREADY of the granted master = ARREADY_S; the other master's ARREADY=0.
  - On ARVALID_S && ARREADY_S: capture the granted ARLEN, clear the beat counter, set last_grant=grant, go to DATA.
- DATA:
  - r_sel=grant.
  - RVALID of the granted master = RVALID_S; the other master's RVALID=0.
  - RREADY_S = RREADY of the granted master.
  - Each beat (RVALID_S && RREADY_S) increments the counter.
  - Beat with RLAST_S=1: go to IDLE next cycle.
  - If counter != captured len on that beat, pulse len_err for 1 cycle, registered, asserted the cycle after the last beat.
  - Counter wraps at 2^CNT_BITS. If the counter reaches captured len without RLAST, hold in DATA; the transaction ends only on RLAST.
- Grant stability:
  - Grant never changes outside IDLE.
  - A non-granted master's ARVALID is ignored until the next IDLE arbitration.
  - Its ARREADY stays 0 (AXI VALID-must-hold is the master's duty).
- Back-to-back: the IDLE cycle after RLAST is mandatory. Minimum turnaround from last R beat to next ARVALID_S is 2 cycles.
- Granted master drops ARVALID in ADDR (protocol violation): ARVALID_S follows it to 0; the FSM stays in ADDR.
- R beats in IDLE/ADDR are not forwarded: RREADY_S=0 and all RVALID_Mx=0.
- Selects: ar_sel and r_sel are driven from the grant register in every state (IDLE included), so muxes never see X.
- busy = (state != IDLE).
- Reset asserted mid-transaction: return immediately to reset values. Outstanding slave beats are the slave's responsibility; the arbiter drops all handshakes.

Test Plan:
- Single M0 read: ARVALID_M0=1, ARLEN_M0=3, ARREADY_S on cycle 2 after grant, 4 R beats with RLAST on 4th -> ARVALID_S high from cycle 1, ar_sel=r_sel=SEL0, RVALID_M0 mirrors RVALID_S, RVALID_M1=0, len_err stays 0, busy falls 1 cycle after last beat.
- Simultaneous requests from reset: both ARVALID high, each len 0 -> M0 served first, then M1; after M1 both request again -> M0 granted (round-robin alternation over 4 transactions: M0,M1,M0,M1).
- Length mismatch: grant M1 with ARLEN_M1=2, slave asserts RLAST on beat 2 -> transaction closes, len_err pulses exactly 1 cycle, next arbitration proceeds normally.
- Backpressure: RREADY_M0 toggles 1,0,0,1 during a 4-beat burst, RVALID_S held -> RREADY_S follows RREADY_M0, counter advances only on handshake cycles, no len_err.
- Late requester: M1 raises ARVALID while M0 is in DATA -> ARREADY_M1 stays 0 and ar_sel stays SEL0 until M0 RLAST; M1 granted in the following IDLE cycle.
- Async reset mid-burst: ARESETn low during DATA beat 2 -> all outputs 0 and busy=0 without waiting for ACLK; after release, first grant goes to M0.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Shared-read-path bundle for the two-master AXI read arbiter.
// Carries the AR/R handshakes of masters M0/M1, the shared slave-side
// handshakes, the payload mux selects and the arbiter status outputs.
// Modports:
//   master - the arbiter itself (it masters the shared slave path)
//   slave  - the surrounding environment (masters, slave, payload muxes)
`timescale 1ns/1ps

`ifndef AXI_POINTER_BITS
`define AXI_POINTER_BITS 1
`endif

interface axi_read_arbiter_if #(
  parameter int unsigned LEN_BITS = 4
);
  // M0 side
  logic                         ARVALID_M0;
  logic [LEN_BITS-1:0]          ARLEN_M0;
  logic                         ARREADY_M0;
  logic                         RVALID_M0;
  logic                         RREADY_M0;
  // M1 side
  logic                         ARVALID_M1;
  logic [LEN_BITS-1:0]          ARLEN_M1;
  logic                         ARREADY_M1;
  logic                         RVALID_M1;
  logic                         RREADY_M1;
  // Shared slave side
  logic                         ARVALID_S;
  logic                         ARREADY_S;
  logic                         RVALID_S;
  logic                         RLAST_S;
  logic                         RREADY_S;
  // Mux selects and status
  logic [`AXI_POINTER_BITS-1:0] ar_sel;
  logic [`AXI_POINTER_BITS-1:0] r_sel;
  logic                         len_err;
  logic                         busy;

  modport master (
    input  ARVALID_M0, ARLEN_M0, RREADY_M0,
    input  ARVALID_M1, ARLEN_M1, RREADY_M1,
    input  ARREADY_S, RVALID_S, RLAST_S,
    output ARREADY_M0, RVALID_M0,
    output ARREADY_M1, RVALID_M1,
    output ARVALID_S, RREADY_S,
    output ar_sel, r_sel, len_err, busy
  );

  modport slave (
    output ARVALID_M0, ARLEN_M0, RREADY_M0,
    output ARVALID_M1, ARLEN_M1, RREADY_M1,
    output ARREADY_S, RVALID_S, RLAST_S,
    input  ARREADY_M0, RVALID_M0,
    input  ARREADY_M1, RVALID_M1,
    input  ARVALID_S, RREADY_S,
    input  ar_sel, r_sel, len_err, busy
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: one transaction in flight, round-robin
// grant held from AR handshake until the RLAST beat.
// Ports:
//   ACLK    - clock
//   ARESETn - asynchronous active-low reset
//   bus     - axi_read_arbiter_if.master: M0/M1 AR+R handshakes, shared
//             slave handshakes, ar_sel/r_sel mux selects, len_err, busy
`timescale 1ns/1ps

`ifndef AXI_POINTER_BITS
`define AXI_POINTER_BITS 1
`endif

module axi_read_arbiter #(
  parameter int unsigned LEN_BITS = 4,
  parameter int unsigned CNT_BITS = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  axi_read_arbiter_if.master  bus
);

  localparam int unsigned SEL_BITS = `AXI_POINTER_BITS;
  localparam logic [SEL_BITS-1:0] SEL0 = SEL_BITS'(0);
  localparam logic [SEL_BITS-1:0] SEL1 = SEL_BITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_BITS-1:0] grant_q, grant_d;
  logic [SEL_BITS-1:0] last_grant_q, last_grant_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                len_err_q, len_err_d;

  logic                gnt_m0;
  logic [LEN_BITS-1:0] arlen_g;
  logic                arvalid_s;
  logic                arready_m0;
  logic                arready_m1;
  logic                rready_s;
  logic                rvalid_m0;
  logic                rvalid_m1;

  assign gnt_m0 = (grant_q == SEL0);

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, round-robin history, beat counter, captured length, error pulse
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_q      <= SEL0;
      last_grant_q <= SEL1;
      cnt_q        <= '0;
      len_q        <= '0;
      len_err_q    <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      len_err_q    <= len_err_d;
    end
  end

  // Next-state, arbitration and handshake gating
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    len_err_d    = 1'b0;
    arvalid_s    = 1'b0;
    arready_m0   = 1'b0;
    arready_m1   = 1'b0;
    rready_s     = 1'b0;
    rvalid_m0    = 1'b0;
    rvalid_m1    = 1'b0;
    arlen_g      = gnt_m0 ? LEN_BITS'(bus.ARLEN_M0) : LEN_BITS'(bus.ARLEN_M1);

    case (state_q)
      IDLE: begin
        // Grant is only ever updated here, so it is stable for the whole transaction.
        if (bus.ARVALID_M0 && bus.ARVALID_M1) begin
          grant_d = (last_grant_q == SEL0) ? SEL1 : SEL0;
          state_d = ADDR;
        end else if (bus.ARVALID_M0) begin
          grant_d = SEL0;
          state_d = ADDR;
        end else if (bus.ARVALID_M1) begin
          grant_d = SEL1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        // A granted master dropping ARVALID just stalls here.
        arvalid_s  = gnt_m0 ? bus.ARVALID_M0 : bus.ARVALID_M1;
        arready_m0 = gnt_m0 & bus.ARREADY_S;
        arready_m1 = !gnt_m0 & bus.ARREADY_S;
        if (arvalid_s && bus.ARREADY_S) begin
          len_d        = arlen_g;
          cnt_d        = '0;
          last_grant_d = grant_q;
          state_d      = DATA;
        end
      end

      DATA: begin
        rvalid_m0 = gnt_m0 & bus.RVALID_S;
        rvalid_m1 = !gnt_m0 & bus.RVALID_S;
        rready_s  = gnt_m0 ? bus.RREADY_M0 : bus.RREADY_M1;
        if (bus.RVALID_S && rready_s) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          // Only RLAST closes the burst; counter holds the index of the current beat.
          if (bus.RLAST_S) begin
            state_d   = IDLE;
            len_err_d = (cnt_q != CNT_BITS'(len_q));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ARVALID_S  = arvalid_s;
  assign bus.ARREADY_M0 = arready_m0;
  assign bus.ARREADY_M1 = arready_m1;
  assign bus.RREADY_S   = rready_s;
  assign bus.RVALID_M0  = rvalid_m0;
  assign bus.RVALID_M1  = rvalid_m1;
  assign bus.ar_sel     = grant_q;
  assign bus.r_sel      = grant_q;
  assign bus.len_err    = len_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
